string_run_expander: RTL
========================

Name: string_run_expander

Overview:
- Inverse of the string run counter: accepts 160-bit run records {string, count} and replays each 128-bit string (16 ASCII chars) count times on a valid/ready output stream.
- Sits on the decompression path, between the record reader (memory/FIFO) and the downstream string consumer.
- Single-record holding register plus a repetition down-counter.
- Back-to-back records stream with no bubble.

Parameters:
- STR_W, 128, string width in bits (16 ASCII bytes).
- CNT_W, 32, repetition count width; record width = STR_W+CNT_W.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  global advance; low freezes all state.
- InRecord  input  160  record: [159:32] string, [31:0] count (count = number of occurrences).
- in_valid  input  1  InRecord valid.
- in_ready  output  1  block accepts InRecord this cycle (combinational).
- OutString  output  128  replayed string (registered).
- out_valid  output  1  OutString valid (registered).
- out_ready  input  1  downstream accepts OutString.
- out_last  output  1  current OutString is the final repetition of its record (registered).
- records_done  output  32  count of fully replayed records, count>=1 only (wraps).

Behaviour:
- Reset (sync, wins over everything): out_valid=0, out_last=0, OutString=0, remaining=0, records_done=0. Reset asserted mid-run discards the record; the next accepted record starts fresh.
- States:
  - IDLE: out_valid=0.
  - EMIT: out_valid=1, remaining = repetitions left, including the one presented.
- Definitions:
  - in_ready = enable && (!out_valid || (out_ready && out_last)).
  - accept = in_valid && in_ready.
  - ohs = enable && out_valid && out_ready.
- enable=0: no register changes; in_ready=0; outputs hold.
- Accept with count>=1: next edge loads OutString=string, remaining=count, out_valid=1, out_last=(count==1). Latency is one cycle: first repetition is visible the cycle after accept.
- Accept with count==0: record consumed and dropped, no output. State after the edge is IDLE, even if a last repetition retired in the same cycle. records_done is unchanged by the zero-count record.
- ohs with remaining>1: remaining-=1; out_last=(remaining-1==1); OutString unchanged.
- ohs with out_last=1:
  - records_done+=1.
  - If accept in the same cycle with count>=1: load the new record; out_valid stays 1 (no bubble).
  - Otherwise: out_valid=0, out_last=0.
- Stall: while out_valid && !out_ready, OutString, out_last and remaining hold stable. in_valid is ignored unless out_last && out_ready.
- Count 0xFFFFFFFF is legal: the block emits 4294967295 repetitions. remaining never underflows.
- records_done wraps 0xFFFFFFFF -> 0.
- in_valid is not required to be held; the block samples it only on accept.
- Sizing: no internal FIFO; throughput is one string per cycle when out_ready=1.

Test Plan:
- Basic run: reset, then InRecord={"AAABBBCCC",32'd3}, in_valid one cycle, out_ready=1 -> out_valid high for exactly 3 cycles starting the cycle after accept. OutString="AAABBBCCC" on all 3; out_last only on the 3rd; records_done=1.
- Back-to-back: {"xxxxxxxxx",2} then {"llllllllll",1} with in_valid held, out_ready=1 -> 3 consecutive valid cycles with no gap: x,x(last),l(last). in_ready high only in the accept cycles. records_done=2.
- Backpressure: {"AAABBBCCC",2} with out_ready=0 for 4 cycles, then 1 -> OutString/out_last stable during the stall, in_ready=0, then 2 handshakes.
- Zero count: {"ZZZZ",0} then {"QQQQ",1} -> no ZZZZ output, one QQQQ output, records_done=1. Also a zero-count record accepted on the last handshake -> out_valid drops next cycle.
- enable gating: deassert enable mid-run of count 4 for 3 cycles with out_ready=1 -> no handshakes and in_ready=0; the remaining repetitions finish after enable returns (4 total).
- Reset mid-run: reset during repetition 2 of 5 -> next cycle out_valid=0, records_done=0; a subsequent record replays correctly.

Source files
------------

// File: rtl/string_run_expander.sv
// Replays each {string, count} run record as `count` consecutive strings on a
// valid/ready stream; zero-count records are consumed silently.
module string_run_expander #(
  parameter int STR_W = 128,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [STR_W+CNT_W-1:0] InRecord,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [STR_W-1:0]       OutString,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [31:0]            records_done
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t             state_q, state_d;
  logic [STR_W-1:0]   str_q, str_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic               last_q, last_d;
  logic [31:0]        done_q, done_d;

  logic [CNT_W-1:0]   recCount;
  logic [STR_W-1:0]   recString;
  logic               accept;
  logic               ohs;

  assign recCount  = InRecord[CNT_W-1:0];
  assign recString = InRecord[STR_W+CNT_W-1:CNT_W];

  // A new record may enter while idle or on the handshake of the final repetition.
  assign in_ready = enable && ((state_q == IDLE) || (out_ready && last_q));
  assign accept   = in_valid && in_ready;
  assign ohs      = enable && (state_q == EMIT) && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      str_q       <= '0;
      remaining_q <= '0;
      last_q      <= 1'b0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      str_q       <= str_d;
      remaining_q <= remaining_d;
      last_q      <= last_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    str_d       = str_q;
    remaining_d = remaining_q;
    last_d      = last_q;
    done_d      = done_q;

    if (ohs) begin
      if (last_q) begin
        done_d      = done_q + 32'd1;
        state_d     = IDLE;
        remaining_d = '0;
        last_d      = 1'b0;
      end else begin
        remaining_d = remaining_q - {{(CNT_W-1){1'b0}}, 1'b1};
        last_d      = (remaining_q == {{(CNT_W-2){1'b0}}, 2'd2});
      end
    end

    // accept only fires when idle or retiring, so a zero count leaves IDLE as set above
    if (accept && (recCount != '0)) begin
      state_d     = EMIT;
      str_d       = recString;
      remaining_d = recCount;
      last_d      = (recCount == {{(CNT_W-1){1'b0}}, 1'b1});
    end
  end

  assign OutString    = str_q;
  assign out_valid    = (state_q == EMIT);
  assign out_last     = last_q;
  assign records_done = done_q;

endmodule
